// File: rtl/rails_pkg.sv
// Shared definitions for the railway stack-sortability checker: FSM states and default sizing.
package rails_pkg;
    localparam int DEF_MAX_N  = 10;
    localparam int DEF_DEPTH1 = 6;
    localparam int DEF_DEPTH2 = 4;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        POP1,
        PUSH1,
        DONE1,
        CLR,
        POP2,
        PUSH2,
        DONE2
    } state_t;
endpackage

// File: rtl/rails_stack.sv
// Parameterised LIFO shared by both checker stages; single-cycle push/pop/clear.
module rails_stack #(
    parameter int DW    = 4,
    parameter int DEPTH = 6,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [DW-1:0] i_dat,
    output logic [DW-1:0] o_top,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    // Sized to the full index range so the count can address it without width games.
    localparam int MEM = 1 << CW;

    logic [DW-1:0] r_mem [0:MEM-1];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_top_idx;

    assign o_count   = r_cnt;
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_top_idx = r_cnt - CW'(1);
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_clear) begin
            r_mem[r_cnt] <= i_dat;
        end
    end
endmodule

// File: rtl/rails_param.sv
// Checks whether target train orders are reachable through bounded stacks (stage 1: 1..n -> data1,
// stage 2: data1 -> data2). RAILS_CASCADE_EN enables stage 2; otherwise result2 is always 0.
module rails_param
    import rails_pkg::*;
#(
    parameter int MAX_N  = DEF_MAX_N,
    parameter int DEPTH1 = DEF_DEPTH1,
    parameter int DEPTH2 = DEF_DEPTH2,
    localparam int W     = $clog2(MAX_N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] number,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    output logic         busy,
    output logic         valid,
    output logic         result1,
    output logic         result2
);
    localparam int DS  = (DEPTH1 > DEPTH2) ? DEPTH1 : DEPTH2;
    localparam int SCW = $clog2(DS + 1);
    localparam int AW  = 1 << W;
    localparam logic [SCW-1:0] CAP1 = SCW'(DEPTH1);

    state_t         r_state, w_next;
    logic [W-1:0]   r_n, r_ld, r_idx, r_src;
    logic [W-1:0]   r_d1 [0:AW-1];
    logic           r_pass, r_res1, r_valid, r_out1, r_out2;

    logic [W-1:0]   w_top, w_tgt, w_srcv;
    logic [SCW-1:0] w_cnt, w_cap;
    logic           w_full, w_empty, w_push, w_pop, w_clear;
    logic           w_num_ok, w_match, w_done_stage, w_fail, w_thru;

`ifdef RAILS_CASCADE_EN
    localparam logic [SCW-1:0] CAP2 = SCW'(DEPTH2);
    logic [W-1:0] r_d2 [0:AW-1];
    logic         w_stage2;

    assign w_stage2 = (r_state == POP2) || (r_state == PUSH2);
    assign w_tgt    = w_stage2 ? r_d2[r_idx] : r_d1[r_idx];
    assign w_srcv   = w_stage2 ? r_d1[r_src] : r_src + W'(1);
    assign w_cap    = w_stage2 ? CAP2 : CAP1;
`else
    logic w_unused;

    assign w_unused = ^data2;
    assign w_tgt    = r_d1[r_idx];
    assign w_srcv   = r_src + W'(1);
    assign w_cap    = CAP1;
`endif

    assign busy    = (r_state != IDLE);
    assign valid   = r_valid;
    assign result1 = r_out1;
    assign result2 = r_out2;

    assign w_num_ok     = (number != '0) && (number <= W'(MAX_N));
    assign w_match      = !w_empty && (r_idx != r_n) && (w_top == w_tgt);
    assign w_done_stage = (r_idx == r_n);
    assign w_fail       = (r_src == r_n) || w_full || (w_cnt == w_cap);
    // A source car equal to the current target passes straight through, so a
    // pushed car can never match and PUSH may keep pushing without re-checking.
    assign w_thru       = (w_srcv == w_tgt);

    rails_stack #(.DW(W), .DEPTH(DS)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_dat   (w_srcv),
        .o_top   (w_top),
        .o_count (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next  = r_state;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_clear = 1'b1;
                w_next  = w_num_ok ? LOAD : DONE2;
            end
            LOAD: if (r_ld == r_n - W'(1)) w_next = POP1;
            POP1: if (w_match) w_pop = 1'b1; else w_next = PUSH1;
            PUSH1: begin
                if (w_done_stage || w_fail) w_next = DONE1;
                else if (w_thru)            w_next = POP1;
                else                        w_push = 1'b1;
            end
`ifdef RAILS_CASCADE_EN
            DONE1: w_next = CLR;
            CLR: begin
                w_clear = 1'b1;
                w_next  = POP2;
            end
            POP2: if (w_match) w_pop = 1'b1; else w_next = PUSH2;
            PUSH2: begin
                if (w_done_stage || w_fail) w_next = DONE2;
                else if (w_thru)            w_next = POP2;
                else                        w_push = 1'b1;
            end
`else
            DONE1: w_next = DONE2;
`endif
            DONE2:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_ld    <= '0;
            r_idx   <= '0;
            r_src   <= '0;
            r_pass  <= 1'b0;
            r_res1  <= 1'b0;
            r_valid <= 1'b0;
            r_out1  <= 1'b0;
            r_out2  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            r_out1  <= 1'b0;
            r_out2  <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_n    <= number;
                    r_ld   <= '0;
                    r_idx  <= '0;
                    r_src  <= '0;
                    r_pass <= 1'b0;
                    r_res1 <= 1'b0;
                end
                LOAD: r_ld <= r_ld + W'(1);
                POP1, POP2: if (w_match) r_idx <= r_idx + W'(1);
                PUSH1, PUSH2: begin
                    if (w_done_stage || w_fail) begin
                        r_pass <= w_done_stage;
                    end else begin
                        r_src <= r_src + W'(1);
                        if (w_thru) r_idx <= r_idx + W'(1);
                    end
                end
                DONE1: r_res1 <= r_pass;
                CLR: begin
                    r_idx <= '0;
                    r_src <= '0;
                end
                DONE2: begin
                    r_valid <= 1'b1;
                    r_out1  <= r_res1;
`ifdef RAILS_CASCADE_EN
                    r_out2  <= r_res1 & r_pass;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            r_d1[r_ld] <= data1;
`ifdef RAILS_CASCADE_EN
            r_d2[r_ld] <= data2;
`endif
        end
    end
endmodule

// File: tb/tb_rails_param.sv
// Randomised scoreboard bench for rails_param with a queue-based reachability reference model.
module tb_rails_param;
    localparam int MAX_N = 10, DEPTH1 = 6, DEPTH2 = 4, W = 4;

    logic clk = 1'b0;
    logic reset, start;
    logic [W-1:0] number, data1, data2;
    logic busy, valid, result1, result2;

    rails_param #(.MAX_N(MAX_N), .DEPTH1(DEPTH1), .DEPTH2(DEPTH2)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .number  (number),
        .data1   (data1),
        .data2   (data2),
        .busy    (busy),
        .valid   (valid),
        .result1 (result1),
        .result2 (result2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r1;
        bit r2;
        int start_cyc;
        int lat_max;
        bit exact;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int checks = 0, errors = 0, cyc = 0;
    logic [3:0] a[16], b[16], src1[16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endfunction

    // A target order is reachable when, repeatedly releasing matching cars from the
    // siding and otherwise parking the next source car, every target car leaves.
    function automatic bit stage_ok(input logic [3:0] src[16], input logic [3:0] tgt[16],
                                    input int n, input int cap);
        logic [3:0] st[$];
        int i = 0;
        int s = 0;
        while (1) begin
            while (st.size() > 0 && i < n && st[$] == tgt[i]) begin
                void'(st.pop_back());
                i++;
            end
            if (i == n) return 1'b1;
            if (s == n || st.size() == cap) return 1'b0;
            st.push_back(src[s]);
            s++;
        end
        return 1'b0;
    endfunction

    function automatic void gen_perm(input logic [3:0] src[16], input int n, input int cap,
                                     output logic [3:0] dst[16]);
        logic [3:0] st[$];
        int s = 0;
        int k = 0;
        dst = '{default: 4'd0};
        while (k < n) begin
            if (st.size() > 0 && (s == n || st.size() >= cap || $urandom_range(0, 1) == 1)) begin
                dst[k] = st.pop_back();
                k++;
            end else begin
                st.push_back(src[s]);
                s++;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid got valid=1 want no pending check");
                end else begin
                    m_e = sb.pop_front();
                    chk("result1", int'(result1), int'(m_e.r1));
                    chk("result2", int'(result2), int'(m_e.r2));
                    if (m_e.exact) begin
                        chk("latency_bad_n", cyc - m_e.start_cyc, m_e.lat_max);
                    end else begin
                        checks++;
                        if (cyc - m_e.start_cyc > m_e.lat_max) begin
                            errors++;
                            $display("FAIL latency got %0d want <= %0d",
                                     cyc - m_e.start_cyc, m_e.lat_max);
                        end
                    end
                end
            end else begin
                chk("idle_results", int'({result1, result2}), 0);
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int k = 0; k < 400 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got busy=1 want 0 within 400 cycles", name);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        bit ok;
        ok = (n >= 1 && n <= MAX_N);
        wait_idle("pre_start");
        @(posedge clk);
        #1;
        start  = 1'b1;
        number = 4'(n);
        e.start_cyc = cyc;
        e.r1 = ok ? stage_ok(src1, a, n, DEPTH1) : 1'b0;
`ifdef RAILS_CASCADE_EN
        e.r2 = e.r1 && stage_ok(a, b, n, DEPTH2);
        e.lat_max = ok ? 5 * n + 8 : 2;
`else
        e.r2 = 1'b0;
        e.lat_max = ok ? 3 * n + 5 : 2;
`endif
        e.exact = !ok;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                data1 = a[i];
                data2 = b[i];
                @(posedge clk);
                #1;
            end
        end else begin
            chk("busy_bad_n_1", int'(busy), 1);
            @(posedge clk);
            #1;
            chk("busy_bad_n_2", int'(busy), 0);
        end
        wait_idle("run");
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [63:0] pa, input logic [63:0] pb);
        for (int i = 0; i < 16; i++) begin
            a[i] = (i < n) ? pa[4*(n-1-i) +: 4] : 4'd0;
            b[i] = (i < n) ? pb[4*(n-1-i) +: 4] : 4'd0;
        end
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_valid"}, int'(valid), 0);
        chk({name, "_res"}, int'({result1, result2}), 0);
    endtask

    initial begin
        int n, mode;
        for (int i = 0; i < 16; i++) src1[i] = 4'(i + 1);
        reset = 1'b1; start = 1'b0; number = '0; data1 = '0; data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        start = 1'b1; number = 4'd3;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        chk("start_in_reset_busy", int'(busy), 0);

        load(5, 64'h54321, 64'h12345); run(5);
        load(3, 64'h312, 64'h123);     run(3);
        load(7, 64'h7654321, 64'h1234567); run(7);
        load(4, 64'h1234, 64'h1234);   run(4);
        run(0);
        run(13);

        // Abort a long check part-way through stage 1; no result may appear for it.
        load(7, 64'h7654321, 64'h1234567);
        @(posedge clk);
        #1;
        start = 1'b1; number = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            data1 = a[i]; data2 = b[i];
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("abort");
        repeat (3) @(posedge clk);
        #1;
        load(2, 64'h21, 64'h12); run(2);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(11, 15);
            else n = $urandom_range(1, MAX_N);
            mode = $urandom_range(0, 2);
            if (n >= 1 && n <= MAX_N) begin
                if (mode == 1) begin
                    for (int i = 0; i < 16; i++) begin
                        a[i] = 4'($urandom_range(0, 15));
                        b[i] = 4'($urandom_range(0, 15));
                    end
                end else begin
                    gen_perm(src1, n, $urandom_range(1, n), a);
                    if (mode == 2) b = a;
                    else gen_perm(a, n, $urandom_range(1, n), b);
                end
            end
            run(n);
        end

        wait_idle("final");
        repeat (3) @(posedge clk);
        #1;
        chk("missing_valid", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish before 500000");
        $fatal(1);
    end
endmodule
